// File: rtl/regfile_scoreboard.sv
// Register file with one write port, two combinational read ports and a pending bit per register.
// Latency: reads are zero-latency (optional same-cycle write bypass); writes and pending bits update on falling clk.
// Backpressure: none; every write and issue strobe presented before a falling edge is taken on that edge.
module regfile_scoreboard #(
  parameter int  WIDTH    = 32,
  parameter int  DEPTH    = 32,
  parameter bit  ZERO_REG = 1'b1,
  parameter bit  BYPASS   = 1'b1,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              pend_set,
  input  logic [ADDR_W-1:0] pend_addr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_a,
  output logic [WIDTH-1:0]  rd_data_b,
  output logic              rd_pend_a,
  output logic              rd_pend_b
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] pend;
  logic [DEPTH-1:0] pend_nxt;
  logic             wr_ok;
  logic             set_ok;
  logic             byp_ok;

  // With a hardwired zero register, strobes aimed at address 0 are simply dropped.
  assign wr_ok  = wr_en && !(ZERO_REG && (wr_addr == '0));
  assign set_ok = pend_set && !(ZERO_REG && (pend_addr == '0));
  assign byp_ok = BYPASS && wr_ok && !reset;

  // Clear first, then set: a new producer issued on the retiring edge keeps the register pending.
  always_comb begin
    pend_nxt = pend;
    if (wr_ok) pend_nxt[wr_addr] = 1'b0;
    if (set_ok) pend_nxt[pend_addr] = 1'b1;
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      pend <= '0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      pend <= pend_nxt;
      if (wr_ok) regs[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_a = regs[rd_addr_a];
    rd_pend_a = pend[rd_addr_a];
    if (byp_ok && (wr_addr == rd_addr_a)) begin
      rd_data_a = wr_data;
      rd_pend_a = 1'b0;
    end
    if (ZERO_REG && (rd_addr_a == '0)) begin
      rd_data_a = '0;
      rd_pend_a = 1'b0;
    end
  end

  always_comb begin
    rd_data_b = regs[rd_addr_b];
    rd_pend_b = pend[rd_addr_b];
    if (byp_ok && (wr_addr == rd_addr_b)) begin
      rd_data_b = wr_data;
      rd_pend_b = 1'b0;
    end
    if (ZERO_REG && (rd_addr_b == '0)) begin
      rd_data_b = '0;
      rd_pend_b = 1'b0;
    end
  end

endmodule
